// File: rtl/alu_issue_reg.sv
// Decode-to-execute issue register: a main entry plus one skid entry, so decode
// can hand over one op per cycle while id_ready still comes straight from a flop.
module alu_issue_reg #(
    parameter int N  = 32,
    parameter int RW = 4,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [4:0]    id_alu_ctrl,
    input  logic [N-1:0]  id_src_A,
    input  logic [N-1:0]  id_src_B,
    input  logic [RW-1:0] id_rd,
    input  logic          id_we,
    input  logic          flush,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [4:0]    ex_alu_ctrl,
    output logic [N-1:0]  ex_src_A,
    output logic [N-1:0]  ex_src_B,
    output logic [RW-1:0] ex_rd,
    output logic          ex_we,
    output logic          ex_illegal,
    output logic [CW-1:0] issue_count
);

    // Payload layout: {alu_ctrl, src_A, src_B, rd, we, illegal}
    localparam int PW = 5 + N + N + RW + 2;

    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] main_pl_q, main_pl_d;
    logic [PW-1:0] skid_pl_q, skid_pl_d;
    logic [CW-1:0] count_q, count_d;

    logic          legal;
    logic          accept;
    logic          issue;
    logic [PW-1:0] in_pl;

    always_comb begin
        legal = 1'b0;
        case (id_alu_ctrl)
            5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Illegal codes keep their control and operands but never write back.
    assign in_pl  = {id_alu_ctrl, id_src_A, id_src_B, id_rd, id_we & legal, ~legal};
    assign accept = id_valid && id_ready && !flush;
    assign issue  = main_valid_q && ex_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_pl_d    = main_pl_q;
        skid_pl_d    = skid_pl_q;
        count_d      = issue ? count_q + CW'(1) : count_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || ex_ready) begin
            if (skid_valid_q) begin
                main_pl_d    = skid_pl_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_pl_d = in_pl;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_pl_d = in_pl;
                end
            end
        end else if (accept) begin
            // Main is stalled; id_ready guarantees the skid entry is free here.
            skid_pl_d    = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_pl_q    <= '0;
            skid_pl_q    <= '0;
            count_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_pl_q    <= main_pl_d;
            skid_pl_q    <= skid_pl_d;
            count_q      <= count_d;
        end
    end

    assign id_ready    = !skid_valid_q;
    assign ex_valid    = main_valid_q;
    assign issue_count = count_q;
    assign {ex_alu_ctrl, ex_src_A, ex_src_B, ex_rd, ex_we, ex_illegal} = main_pl_q;

endmodule

// File: tb/tb_alu_issue_reg.sv
// Randomized and directed bench for alu_issue_reg against a queue-based model
// of the ops currently held by the block.
module tb_alu_issue_reg;

    localparam int N  = 32;
    localparam int RW = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic [4:0]    ctrl;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [RW-1:0] rd;
        logic          we;
        logic          ill;
    } op_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic          id_ready;
    logic [4:0]    id_alu_ctrl;
    logic [N-1:0]  id_src_A, id_src_B;
    logic [RW-1:0] id_rd;
    logic          id_we;
    logic          flush;
    logic          ex_valid;
    logic          ex_ready;
    logic [4:0]    ex_alu_ctrl;
    logic [N-1:0]  ex_src_A, ex_src_B;
    logic [RW-1:0] ex_rd;
    logic          ex_we;
    logic          ex_illegal;
    logic [CW-1:0] issue_count;

    op_t           dut_op;
    op_t           mq[$];
    logic [CW-1:0] mcnt;
    int            checks = 0;
    int            errors = 0;

    alu_issue_reg #(.N(N), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_alu_ctrl(id_alu_ctrl), .id_src_A(id_src_A), .id_src_B(id_src_B),
        .id_rd(id_rd), .id_we(id_we), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_src_A(ex_src_A), .ex_src_B(ex_src_B),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_illegal(ex_illegal),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    assign dut_op = {ex_alu_ctrl, ex_src_A, ex_src_B, ex_rd, ex_we, ex_illegal};

    // What execute should see for an op decode offered with these fields.
    function automatic op_t mk(input logic [4:0] c, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [RW-1:0] rd,
                               input logic we);
        op_t o;
        logic legal;
        legal = c inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd10, 5'd11, 5'd12};
        o.ctrl = c; o.a = a; o.b = b; o.rd = rd;
        o.we = we && legal;
        o.ill = !legal;
        return o;
    endfunction

    function automatic op_t raw(input logic [4:0] c, input logic [N-1:0] a,
                                input logic [N-1:0] b, input logic [RW-1:0] rd,
                                input logic we);
        op_t o;
        o.ctrl = c; o.a = a; o.b = b; o.rd = rd; o.we = we; o.ill = 1'b0;
        return o;
    endfunction

    // One clock: drive inputs, advance, then update the model of held ops.
    task automatic step(input logic v, input op_t r, input logic fl, input logic er);
        logic acc, iss;
        id_valid = v; id_alu_ctrl = r.ctrl; id_src_A = r.a; id_src_B = r.b;
        id_rd = r.rd; id_we = r.we; flush = fl; ex_ready = er;
        acc = v && (mq.size() < 2) && !fl;
        iss = (mq.size() > 0) && er;
        @(posedge clk); #1;
        if (iss) begin mq.delete(0); mcnt++; end
        if (fl) mq.delete();
        else if (acc) mq.push_back(mk(r.ctrl, r.a, r.b, r.rd, r.we));
    endtask

    task automatic do_reset();
        rst = 1'b0; id_valid = 0; id_alu_ctrl = 0; id_src_A = 0; id_src_B = 0;
        id_rd = 0; id_we = 0; flush = 0; ex_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        mq.delete(); mcnt = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ex_valid, id_ready, issue_count} !== {1'b0, 1'b1, 4'd0} || dut_op !== '0) begin
            errors++;
            $display("FAIL reset act v=%b rdy=%b cnt=%0d op=%h exp v=0 rdy=1 cnt=0 op=0",
                     ex_valid, id_ready, issue_count, dut_op);
        end
    endtask

    task automatic test_stream();
        logic [CW-1:0] c0;
        c0 = issue_count;
        for (int i = 1; i <= 4; i++) begin
            step(1, raw(5'd1, N'(i), N'(10 * i), RW'(i), 1'b1), 0, 1);
            checks++;
            if (ex_valid !== 1'b1 || dut_op !== mk(5'd1, N'(i), N'(10 * i), RW'(i), 1'b1)) begin
                errors++;
                $display("FAIL stream_op%0d act v=%b op=%h exp v=1 A=%0d", i, ex_valid, dut_op, i);
            end
        end
        step(0, '0, 0, 1);
        checks++;
        if (ex_valid !== 1'b0 || issue_count !== c0 + 4'd4) begin
            errors++;
            $display("FAIL stream_count act v=%b cnt=%0d exp v=0 cnt=%0d",
                     ex_valid, issue_count, c0 + 4'd4);
        end
    endtask

    task automatic test_stall();
        op_t x, y, z;
        x = raw(5'd2, 32'h11, 32'h22, 4'd1, 1'b1);
        y = raw(5'd3, 32'h33, 32'h44, 4'd2, 1'b1);
        z = raw(5'd9, 32'h55, 32'h66, 4'd3, 1'b0);
        step(1, x, 0, 0);
        step(1, y, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, z, 0, 0);
            checks++;
            if (id_ready !== 1'b0 || ex_valid !== 1'b1 || dut_op !== mk(x.ctrl, x.a, x.b, x.rd, x.we)) begin
                errors++;
                $display("FAIL stall_hold%0d act rdy=%b v=%b op=%h exp rdy=0 v=1 op=X", k, id_ready, ex_valid, dut_op);
            end
        end
        step(1, z, 0, 1);
        checks++;
        if (id_ready !== 1'b1 || dut_op !== mk(y.ctrl, y.a, y.b, y.rd, y.we)) begin
            errors++;
            $display("FAIL stall_release act rdy=%b op=%h exp rdy=1 op=Y", id_ready, dut_op);
        end
        step(1, z, 0, 1);
        step(0, '0, 0, 0);
        checks++;
        if (ex_valid !== 1'b1 || dut_op !== mk(z.ctrl, z.a, z.b, z.rd, z.we)) begin
            errors++;
            $display("FAIL stall_z act v=%b op=%h exp v=1 op=Z", ex_valid, dut_op);
        end
        step(0, '0, 0, 1);
    endtask

    task automatic test_illegal();
        step(1, raw(5'd17, 32'd5, 32'd7, 4'd4, 1'b1), 0, 0);
        checks++;
        if ({ex_valid, ex_illegal, ex_we, ex_alu_ctrl} !== {1'b1, 1'b1, 1'b0, 5'd17} || ex_src_A !== 32'd5) begin
            errors++;
            $display("FAIL illegal act v=%b ill=%b we=%b ctrl=%0d A=%0d exp v=1 ill=1 we=0 ctrl=17 A=5",
                     ex_valid, ex_illegal, ex_we, ex_alu_ctrl, ex_src_A);
        end
        step(1, raw(5'd11, 32'hf0, 32'h0f, 4'd5, 1'b1), 0, 1);
        checks++;
        if ({ex_valid, ex_illegal, ex_we, ex_alu_ctrl} !== {1'b1, 1'b0, 1'b1, 5'd11}) begin
            errors++;
            $display("FAIL legal_xor act v=%b ill=%b we=%b ctrl=%0d exp v=1 ill=0 we=1 ctrl=11",
                     ex_valid, ex_illegal, ex_we, ex_alu_ctrl);
        end
        step(0, '0, 0, 1);
    endtask

    task automatic test_flush(input logic er);
        logic [CW-1:0] c0;
        c0 = issue_count;
        step(1, raw(5'd4, 32'd1, 32'd2, 4'd6, 1'b1), 0, 0);
        step(1, raw(5'd10, 32'd3, 32'd4, 4'd7, 1'b1), 0, 0);
        step(1, raw(5'd12, 32'd5, 32'd6, 4'd8, 1'b1), 1, er);
        checks++;
        if ({ex_valid, id_ready, issue_count} !== {1'b0, 1'b1, c0 + CW'(er)}) begin
            errors++;
            $display("FAIL flush_er%0d act v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=%0d",
                     er, ex_valid, id_ready, issue_count, c0 + CW'(er));
        end
        step(0, '0, 0, 1);
        checks++;
        if (ex_valid !== 1'b0 || issue_count !== c0 + CW'(er)) begin
            errors++;
            $display("FAIL flush_after_er%0d act v=%b cnt=%0d exp v=0 cnt=%0d",
                     er, ex_valid, issue_count, c0 + CW'(er));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) step(1, raw(5'd1, N'(i), 0, 0, 1'b1), 0, 1);
        step(0, '0, 0, 1);
        checks++;
        if (issue_count !== 4'd1 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap act cnt=%0d v=%b exp cnt=1 v=0", issue_count, ex_valid);
        end
    endtask

    task automatic test_async_reset();
        op_t w;
        w = raw(5'd3, 32'h77, 32'h88, 4'd9, 1'b1);
        step(1, raw(5'd1, 32'd1, 32'd1, 4'd1, 1'b1), 0, 0);
        step(1, raw(5'd2, 32'd2, 32'd2, 4'd2, 1'b1), 0, 0);
        id_valid = 0;
        #3 rst = 1'b0;
        #1;
        checks++;
        if ({ex_valid, id_ready, issue_count} !== {1'b0, 1'b1, 4'd0} || dut_op !== '0) begin
            errors++;
            $display("FAIL async_reset act v=%b rdy=%b cnt=%0d op=%h exp v=0 rdy=1 cnt=0 op=0",
                     ex_valid, id_ready, issue_count, dut_op);
        end
        mq.delete(); mcnt = '0;
        #2 rst = 1'b1;
        step(1, w, 0, 0);
        checks++;
        if (ex_valid !== 1'b1 || dut_op !== mk(w.ctrl, w.a, w.b, w.rd, w.we)) begin
            errors++;
            $display("FAIL async_release act v=%b op=%h exp v=1 op=%h",
                     ex_valid, dut_op, mk(w.ctrl, w.a, w.b, w.rd, w.we));
        end
        step(0, '0, 0, 1);
    endtask

    task automatic test_random();
        logic [4:0] c;
        for (int i = 0; i < 400; i++) begin
            checks++;
            if ({ex_valid, id_ready, issue_count} !== {mq.size() > 0, mq.size() < 2, mcnt}) begin
                errors++;
                $display("FAIL rand_status cyc%0d act v=%b rdy=%b cnt=%0d exp v=%b rdy=%b cnt=%0d",
                         i, ex_valid, id_ready, issue_count, mq.size() > 0, mq.size() < 2, mcnt);
            end
            if (mq.size() > 0) begin
                checks++;
                if (dut_op !== mq[0]) begin
                    errors++;
                    $display("FAIL rand_op cyc%0d act %h exp %h", i, dut_op, mq[0]);
                end
            end
            c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'($urandom_range(1, 4));
            step($urandom_range(0, 3) != 0,
                 raw(c, $urandom, $urandom, RW'($urandom), 1'($urandom)),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_illegal();
        test_flush(1'b0);
        test_flush(1'b1);
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
